// File: rtl/pwm11_decode_pkg.sv
// Shared types and defaults for the PWM duty decoder.
// Filter depth applies only when PWM_DEC_GLITCH_FILTER_EN is defined.
package pwm_dec_pkg;

   localparam int PERIOD_DEF = 2048;
   localparam int DW_DEF     = 11;
   localparam int FILT_DEPTH = 3;

   typedef enum logic [0:0] {
      SYNC = 1'b0,
      MEAS = 1'b1
   } dec_state_t;

endpackage

// File: rtl/pwm11_decode_if.sv
// PWM decoder signal bundle: raw PWM pin in, measured duty and status out.
// master = side that drives the pin and reads results, slave = decoder.
interface pwm_dec_if
   import pwm_dec_pkg::*;
#(
   parameter int DW = DW_DEF
);
   logic          PWM_sig;
   logic [DW-1:0] duty;
   logic          vld;
   logic          err;
   logic          stuck_hi;

   modport master (
      output PWM_sig,
      input  duty,
      input  vld,
      input  err,
      input  stuck_hi
   );

   modport slave (
      input  PWM_sig,
      output duty,
      output vld,
      output err,
      output stuck_hi
   );
endinterface

// File: rtl/pwm11_decode_sync_edge.sv
// Pin conditioning: 2-flop synchronizer, rising-edge detect, and an optional
// persistence filter enabled by PWM_DEC_GLITCH_FILTER_EN.
module pwm_sync_edge
   import pwm_dec_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level,
   output logic rise
);

   logic [1:0] sync_q;
   logic       level_dly_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], pin};
      end
   end

`ifdef PWM_DEC_GLITCH_FILTER_EN
   // Level only moves once FILT_DEPTH consecutive synced samples agree.
   logic [FILT_DEPTH-2:0] hist_q;
   logic [FILT_DEPTH-1:0] win;
   logic                  filt_q;

   assign win = {hist_q, sync_q[1]};

   always_comb begin
      level = filt_q;
      if (&win) begin
         level = 1'b1;
      end else if (~|win) begin
         level = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_q <= '0;
         filt_q <= 1'b0;
      end else begin
         hist_q <= win[FILT_DEPTH-2:0];
         filt_q <= level;
      end
   end
`else
   assign level = sync_q[1];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_dly_q <= 1'b0;
      end else begin
         level_dly_q <= level;
      end
   end

   assign rise = level & ~level_dly_q;

endmodule

// File: rtl/pwm11_decode.sv
// PWM duty decoder: locks to rising edges and publishes the high-sample count
// of every PERIOD-long period. Optional pin glitch filter: PWM_DEC_GLITCH_FILTER_EN.
//
// state | meaning
// SYNC  | waiting for a first rising edge; per_cnt runs only for timeout
// MEAS  | locked; each rise closes a period and is checked against PERIOD
module pwm11_decode
   import pwm_dec_pkg::*;
#(
   parameter int PERIOD = PERIOD_DEF,
   parameter int DW     = DW_DEF
)(
   input  logic      clk,
   input  logic      rst,
   pwm_dec_if.slave  bus
);

   localparam int            CW       = DW + 1;
   localparam logic [CW-1:0] PER_LAST = CW'(PERIOD - 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(2 * PERIOD - 1);
   localparam logic [DW-1:0] DUTY_MAX = '1;

   dec_state_t    state_q;
   dec_state_t    state_nxt;
   logic          level;
   logic          rise;
   logic [CW-1:0] per_cnt;
   logic [CW-1:0] hi_cnt;
   logic          ev_ok;
   logic          ev_bad;
   logic          ev_tmo;
   logic [DW-1:0] duty_pub;

   logic [DW-1:0] duty_q;
   logic [DW-1:0] duty_nxt;
   logic          vld_q;
   logic          vld_nxt;
   logic          err_q;
   logic          err_nxt;
   logic          stuck_q;
   logic          stuck_nxt;

   pwm_sync_edge u_sync_edge (
      .clk   (clk),
      .rst   (rst),
      .pin   (bus.PWM_sig),
      .level (level),
      .rise  (rise)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SYNC;
      end else begin
         state_q <= state_nxt;
      end
   end

   // A rise on the timeout cycle wins; the timeout is simply not raised.
   always_comb begin
      state_nxt = state_q;
      ev_ok     = 1'b0;
      ev_bad    = 1'b0;
      ev_tmo    = 1'b0;
      if (rise) begin
         state_nxt = MEAS;
         if (state_q == MEAS) begin
            if (per_cnt == PER_LAST) begin
               ev_ok = 1'b1;
            end else begin
               ev_bad = 1'b1;
            end
         end
      end else if (per_cnt == TMO_LAST) begin
         ev_tmo    = 1'b1;
         state_nxt = SYNC;
      end
   end

   assign duty_pub = (hi_cnt > {1'b0, DUTY_MAX}) ? DUTY_MAX : hi_cnt[DW-1:0];

   always_comb begin
      duty_nxt  = duty_q;
      vld_nxt   = 1'b0;
      err_nxt   = 1'b0;
      stuck_nxt = stuck_q;
      if (ev_ok) begin
         duty_nxt  = duty_pub;
         vld_nxt   = 1'b1;
         stuck_nxt = 1'b0;
      end else if (ev_bad) begin
         err_nxt   = 1'b1;
         stuck_nxt = 1'b0;
      end else if (ev_tmo) begin
         vld_nxt = 1'b1;
         if (level) begin
            duty_nxt  = DUTY_MAX;
            stuck_nxt = 1'b1;
         end else begin
            duty_nxt = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty_q  <= '0;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
         stuck_q <= 1'b0;
      end else begin
         duty_q  <= duty_nxt;
         vld_q   <= vld_nxt;
         err_q   <= err_nxt;
         stuck_q <= stuck_nxt;
      end
   end

   // hi_cnt starts at 1 because the rise cycle itself is a high sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         per_cnt <= '0;
         hi_cnt  <= '0;
      end else if (rise) begin
         per_cnt <= '0;
         hi_cnt  <= CW'(1);
      end else if (ev_tmo) begin
         per_cnt <= '0;
         hi_cnt  <= '0;
      end else begin
         per_cnt <= per_cnt + 1'b1;
         if (state_q == MEAS) begin
            hi_cnt <= hi_cnt + CW'(level);
         end
      end
   end

   assign bus.duty     = duty_q;
   assign bus.vld      = vld_q;
   assign bus.err      = err_q;
   assign bus.stuck_hi = stuck_q;

endmodule
